sign_mem_writer: RTL and testbench

- Write-side controller for the 64x6 sign-code memory. It is the producer counterpart of the address-driven memory read path.
- Accepts a burst of 6-bit sign codes from the classifier over a valid/ready handshake and drives a registered write port (WE/WADD/WDATA) into the memory array.
- Writes start at a programmable base address. The address pointer auto-increments and wraps modulo DEPTH.
- Signals burst completion with a one-cycle DONE pulse.

---
 rtl/sign_mem_writer.sv | 154 +++++++++++++++
 tb/tb_sign_mem_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sign_mem_writer.sv
// Write-side controller for the sign-code memory: accepts a burst of codes over
// valid/ready and drives a registered write port starting at a programmable base.
module sign_mem_writer #(
   parameter int DATA_W = 6,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [ADDR_W:0]   i_len,
   input  logic              i_in_valid,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_in_ready,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_wadd,
   output logic [DATA_W-1:0] o_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_WRITE = 1'b1
   } state_t;

   localparam logic [ADDR_W:0]   LP_DEPTH    = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W-1:0] LP_LAST_ADR = ADDR_W'(DEPTH - 1);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W:0]     r_cnt;
   logic [ADDR_W:0]     r_len;
   logic                r_in_ready;
   logic                r_we;
   logic [ADDR_W-1:0]   r_wadd;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_busy;
   logic                r_done;
   logic                r_err;

   state_t              w_state_next;
   logic [ADDR_W-1:0]   w_ptr_next;
   logic [ADDR_W:0]     w_cnt_next;
   logic [ADDR_W:0]     w_len_next;
   logic                w_in_ready_next;
   logic                w_we_next;
   logic [ADDR_W-1:0]   w_wadd_next;
   logic [DATA_W-1:0]   w_wdata_next;
   logic                w_busy_next;
   logic                w_done_next;
   logic                w_err_next;

   logic                w_len_ok;
   logic                w_xfer;
   logic                w_last;
   logic [ADDR_W-1:0]   w_ptr_inc;

   assign w_len_ok  = (i_len != '0) && (i_len <= LP_DEPTH);
   assign w_xfer    = (r_state == S_WRITE) && r_in_ready && i_in_valid;
   assign w_last    = (r_cnt == (r_len - (ADDR_W+1)'(1)));
   assign w_ptr_inc = (r_ptr == LP_LAST_ADR) ? '0 : r_ptr + ADDR_W'(1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_cnt      <= '0;
         r_len      <= '0;
         r_in_ready <= 1'b0;
         r_we       <= 1'b0;
         r_wadd     <= '0;
         r_wdata    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_ptr      <= w_ptr_next;
         r_cnt      <= w_cnt_next;
         r_len      <= w_len_next;
         r_in_ready <= w_in_ready_next;
         r_we       <= w_we_next;
         r_wadd     <= w_wadd_next;
         r_wdata    <= w_wdata_next;
         r_busy     <= w_busy_next;
         r_done     <= w_done_next;
         r_err      <= w_err_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_ptr_next      = r_ptr;
      w_cnt_next      = r_cnt;
      w_len_next      = r_len;
      w_in_ready_next = r_in_ready;
      w_we_next       = 1'b0;
      w_wadd_next     = r_wadd;
      w_wdata_next    = r_wdata;
      w_busy_next     = r_busy;
      w_done_next     = 1'b0;
      w_err_next      = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_busy_next     = 1'b0;
            w_in_ready_next = 1'b0;
            // BUSY is still high in the DONE cycle; START waits until it drops.
            if (i_start && !r_busy) begin
               if (w_len_ok) begin
                  w_ptr_next      = i_base;
                  w_len_next      = i_len;
                  w_cnt_next      = '0;
                  w_state_next    = S_WRITE;
                  w_busy_next     = 1'b1;
                  w_in_ready_next = 1'b1;
               end else begin
                  w_err_next = 1'b1;
               end
            end
         end
         S_WRITE: begin
            w_busy_next = 1'b1;
            if (w_xfer) begin
               w_we_next    = 1'b1;
               w_wadd_next  = r_ptr;
               w_wdata_next = i_in_data;
               w_ptr_next   = w_ptr_inc;
               w_cnt_next   = r_cnt + (ADDR_W+1)'(1);
               if (w_last) begin
                  w_in_ready_next = 1'b0;
                  w_done_next     = 1'b1;
                  w_state_next    = S_IDLE;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign o_in_ready = r_in_ready;
   assign o_we       = r_we;
   assign o_wadd     = r_wadd;
   assign o_wdata    = r_wdata;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_err      = r_err;

endmodule

// File: tb/tb_sign_mem_writer.sv
// Directed bench for sign_mem_writer: a words-remaining model checked every cycle,
// plus a write log compared against hand-computed address/data lists.
module tb_sign_mem_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [5:0] base = '0;
   logic [6:0] len = '0;
   logic       in_valid = 1'b0;
   logic [5:0] in_data = '0;
   logic       in_ready, we, busy, done, err;
   logic [5:0] wadd, wdata;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   bit m_started = 0;
   bit m_act = 0;
   int m_rem = 0;
   int m_ptr = 0;
   int e_ready = 0, e_we = 0, e_wadd = 0, e_wdata = 0, e_busy = 0, e_done = 0, e_err = 0;

   typedef struct { int addr; int data; int dn; } wr_t;
   wr_t wlog[$];

   always #5 clk = ~clk;

   sign_mem_writer dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_base(base), .i_len(len),
      .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
      .o_we(we), .o_wadd(wadd), .o_wdata(wdata), .o_busy(busy),
      .o_done(done), .o_err(err)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Burst model: tracks words remaining and the next address, nothing more.
   task automatic model_step();
      bit was_idle;
      bit xfer;
      if (rst) begin
         m_act = 0; m_rem = 0; m_ptr = 0;
         e_ready = 0; e_we = 0; e_wadd = 0; e_wdata = 0;
         e_busy = 0; e_done = 0; e_err = 0;
         return;
      end
      was_idle = !m_act && (e_busy == 0);
      xfer = m_act && in_valid;
      e_we = xfer; e_done = 0; e_err = 0;
      if (xfer) begin
         e_wadd = m_ptr; e_wdata = int'(in_data);
         m_ptr = (m_ptr + 1) % 64;
         m_rem = m_rem - 1;
         if (m_rem == 0) begin
            e_done = 1; m_act = 0;
         end
      end
      if (was_idle && start) begin
         if (len >= 1 && len <= 64) begin
            m_act = 1; m_ptr = int'(base); m_rem = int'(len);
         end else begin
            e_err = 1;
         end
      end
      e_busy = (m_act || e_done) ? 1 : 0;
      e_ready = m_act ? 1 : 0;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
      m_started = 1;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (we) wlog.push_back('{int'(wadd), int'(wdata), int'(done)});
   end

   initial forever begin
      @(negedge clk);
      if (m_started) begin
         check("in_ready", int'(in_ready), e_ready);
         check("we",       int'(we),       e_we);
         check("wadd",     int'(wadd),     e_wadd);
         check("wdata",    int'(wdata),    e_wdata);
         check("busy",     int'(busy),     e_busy);
         check("done",     int'(done),     e_done);
         check("err",      int'(err),      e_err);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start(input int b, input int l);
      @(negedge clk);
      start = 1'b1; base = 6'(b); len = 7'(l);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drive(input bit v, input int d);
      in_valid = v; in_data = 6'(d);
      @(negedge clk);
   endtask

   task automatic check_log(input string name, input int idx, input int a, input int d, input int dn);
      if (idx >= wlog.size()) begin
         check({name, "_present"}, 0, 1);
      end else begin
         check({name, "_addr"}, wlog[idx].addr, a);
         check({name, "_data"}, wlog[idx].data, d);
         check({name, "_done"}, wlog[idx].dn, dn);
      end
   endtask

   initial begin
      int vpat[7];
      // reset, then idle with stray valid data
      cyc(2);
      rst = 1'b0;
      in_valid = 1'b1; in_data = 6'd9;
      cyc(3);
      check("idle_we", int'(we), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_ready", int'(in_ready), 0);
      check("idle_log", wlog.size(), 0);
      in_valid = 1'b0;
      $display("txn reset/idle done");

      // base 5, len 3, consecutive codes
      wlog.delete();
      do_start(5, 3);
      drive(1, 10); drive(1, 11);
      in_valid = 1'b1; in_data = 6'd12;
      @(negedge clk);
      check("b1_done_pulse", int'(done), 1);
      check("b1_last_addr", int'(wadd), 7);
      in_valid = 1'b0;
      @(negedge clk);
      check("b1_busy_after", int'(busy), 0);
      cyc(2);
      check("b1_count", wlog.size(), 3);
      check_log("b1_w0", 0, 5, 10, 0);
      check_log("b1_w1", 1, 6, 11, 0);
      check_log("b1_w2", 2, 7, 12, 1);
      $display("txn burst base=5 len=3 writes=%0d", wlog.size());

      // wrap-around with gapped valid, extra word after the last
      wlog.delete();
      do_start(62, 4);
      vpat = '{1, 0, 1, 1, 0, 1, 1};
      for (int i = 0; i < 7; i++) drive(vpat[i][0], 20 + i);
      in_valid = 1'b0;
      check("wrap_ready_low", int'(in_ready), 0);
      cyc(3);
      check("wrap_count", wlog.size(), 4);
      check_log("wrap_w0", 0, 62, 20, 0);
      check_log("wrap_w1", 1, 63, 22, 0);
      check_log("wrap_w2", 2, 0, 23, 0);
      check_log("wrap_w3", 3, 1, 25, 1);
      $display("txn burst base=62 len=4 gapped writes=%0d", wlog.size());

      // illegal lengths
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         start = 1'b1; base = 6'd3; len = (k == 0) ? 7'd0 : 7'd65;
         @(negedge clk);
         start = 1'b0;
         check("err_pulse", int'(err), 1);
         check("err_busy", int'(busy), 0);
         @(negedge clk);
         check("err_clear", int'(err), 0);
         check("err_ready", int'(in_ready), 0);
         $display("txn start len=%0d rejected", (k == 0) ? 0 : 65);
      end

      // START during a burst is ignored
      wlog.delete();
      do_start(30, 3);
      in_valid = 1'b1; in_data = 6'd1;
      @(negedge clk);
      start = 1'b1; base = 6'd20; len = 7'd5; in_data = 6'd2;
      @(negedge clk);
      start = 1'b0; in_data = 6'd3;
      @(negedge clk);
      in_valid = 1'b0;
      cyc(4);
      check("midstart_count", wlog.size(), 3);
      check_log("mid_w0", 0, 30, 1, 0);
      check_log("mid_w1", 1, 31, 2, 0);
      check_log("mid_w2", 2, 32, 3, 1);
      $display("txn burst base=30 with mid-burst start writes=%0d", wlog.size());

      // reset mid-burst, then fresh single-word burst
      wlog.delete();
      do_start(40, 5);
      drive(1, 4); drive(1, 5);
      rst = 1'b1; in_data = 6'd6;
      @(negedge clk);
      check("rst_we", int'(we), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ready", int'(in_ready), 0);
      rst = 1'b0; in_valid = 1'b0;
      cyc(2);
      check("rst_count", wlog.size(), 2);
      check_log("rst_w0", 0, 40, 4, 0);
      check_log("rst_w1", 1, 41, 5, 0);
      wlog.delete();
      do_start(0, 1);
      drive(1, 33);
      in_valid = 1'b0;
      cyc(3);
      check("fresh_count", wlog.size(), 1);
      check_log("fresh_w0", 0, 0, 33, 1);
      $display("txn reset mid-burst then base=0 len=1 writes=%0d", wlog.size());

      // full-depth burst touches every address once
      wlog.delete();
      do_start(10, 64);
      for (int i = 0; i < 64; i++) drive(1, (i * 7) % 64);
      in_valid = 1'b0;
      cyc(3);
      check("full_count", wlog.size(), 64);
      begin
         bit seen[64];
         int uniq = 0;
         foreach (wlog[i]) if (!seen[wlog[i].addr]) begin seen[wlog[i].addr] = 1; uniq++; end
         check("full_unique", uniq, 64);
      end
      check_log("full_first", 0, 10, 0, 0);
      check_log("full_last", 63, 9, (63 * 7) % 64, 1);
      $display("txn burst base=10 len=64 writes=%0d", wlog.size());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
